// File: rtl/pin_monitor_pkg.sv
// Shared definitions for the pin monitor: phase-tracking FSM states and
// default parameter values used by pin_debounce and pin_monitor.
package pin_monitor_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEBOUNCE_DEF    = 16;
    localparam int CNT_W_DEF       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } phase_state_t;

endpackage

// File: rtl/pin_debounce.sv
// Synchronizes an asynchronous pin into the clk domain and debounces it:
// the output level only follows the sample after DEBOUNCE consecutive differing cycles.
module pin_debounce
    import pin_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEBOUNCE    = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic level
);

    localparam int              DCW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DCW-1:0]  DB_LAST = DCW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DCW-1:0]         r_cnt;
    logic                   r_level;
    logic                   w_sample;
    logic                   w_differs;

    assign w_sample  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sample != r_level);
    assign level     = r_level;

    // Pulled-up line idles high, so the chain resets to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pin_monitor.sv
// Pin monitor top: debounced level, edge strobes, high/low phase measurement
// and a valid/ready handoff of each completed period with sticky overrun.
module pin_monitor
    import pin_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEBOUNCE    = DEBOUNCE_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_in,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] low_count,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    phase_state_t     r_state;
    phase_state_t     w_stateNext;
    logic             w_level;
    logic             r_levelPrev;
    logic             w_rise;
    logic             w_fall;
    logic             w_latchHigh;
    logic             w_capture;
    logic             w_drop;
    logic [CNT_W-1:0] r_phaseCnt;
    logic [CNT_W-1:0] r_highLen;
    logic             r_highValid;
    logic [CNT_W-1:0] r_highCount;
    logic [CNT_W-1:0] r_lowCount;
    logic             r_measValid;
    logic             r_overrun;

    pin_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (pin_in),
        .level  (w_level)
    );

    // Strobes are combinational so they coincide with the first cycle of the new level.
    assign w_rise = w_level & ~r_levelPrev;
    assign w_fall = ~w_level & r_levelPrev;
    assign w_drop = w_capture & r_measValid & ~meas_ready;

    assign level      = w_level;
    assign rise_pulse = w_rise;
    assign fall_pulse = w_fall;
    assign high_count = r_highCount;
    assign low_count  = r_lowCount;
    assign meas_valid = r_measValid;
    assign overrun    = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_levelPrev <= 1'b1;
            r_state     <= ST_IDLE;
        end else begin
            r_levelPrev <= w_level;
            r_state     <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_latchHigh = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_stateNext = ST_LOW;
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_stateNext = ST_LOW;
                    w_latchHigh = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_stateNext = ST_HIGH;
                    w_capture   = r_highValid;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // The edge cycle itself counts as cycle 1 of the new phase, so at the next
    // edge the counter holds the full length of the phase that just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phaseCnt <= '0;
        end else if (w_rise || w_fall) begin
            r_phaseCnt <= CNT_W'(1);
        end else if (r_phaseCnt != '1) begin
            r_phaseCnt <= r_phaseCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_highLen   <= '0;
            r_highValid <= 1'b0;
        end else if (w_latchHigh) begin
            r_highLen   <= r_phaseCnt;
            r_highValid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_highCount <= '0;
            r_lowCount  <= '0;
            r_measValid <= 1'b0;
        end else if (w_capture && !w_drop) begin
            r_highCount <= r_highLen;
            r_lowCount  <= r_phaseCnt;
            r_measValid <= 1'b1;
        end else if (meas_ready) begin
            r_measValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pin_monitor.sv
// Randomized phase-sequence bench for pin_monitor: expected behaviour comes from
// the drawn phase list (fixed latency, phase lengths) and a one-slot handoff model.
module tb_pin_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int DEBOUNCE    = 4;
    localparam int CNT_W       = 8;
    localparam int LAT         = SYNC_STAGES + DEBOUNCE - 1;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pin_in = 1'b1;
    logic             meas_ready = 1'b0;
    logic             overrun_clr = 1'b0;
    logic             level;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] low_count;
    logic             meas_valid;
    logic             overrun;

    int compared = 0;
    int mismatched = 0;

    int forcedLen[$];
    bit glitch0;
    int phaseLen[$];
    int phaseStart[$];
    bit pinSched[$];
    bit cleanSched[$];
    bit readySched[$];
    bit clrSched[$];
    bit capSched[$];
    int capHi[$];
    int capLo[$];

    bit mValid;
    bit mOverrun;
    int mHi;
    int mLo;

    pin_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pin_in      (pin_in),
        .level       (level),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .high_count  (high_count),
        .low_count   (low_count),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic bit inWindow(input int c, input int f, input int t, input int total);
        int lo;
        int hi;
        if (f < 0) return 1'b0;
        lo = phaseStart[f];
        hi = (t < phaseStart.size()) ? phaseStart[t] : total;
        return (c >= lo) && (c < hi);
    endfunction

    // Drives one run of alternating phases (phase 0 high) starting at a negedge
    // right after reset release, and checks every cycle against the phase list.
    task automatic applyStimulus(input string seg, input int nPhases, input int dropTail, input int lastLen,
                                 input int q0f, input int q0t, input int q1f, input int q1t);
        int len;
        int g;
        int total;
        int runLen;
        int m;
        bit lvl;
        bit drop;
        bit expLevel;
        bit prevLevel;
        bit quiet;
        phaseLen.delete(); phaseStart.delete(); pinSched.delete(); cleanSched.delete();
        readySched.delete(); clrSched.delete(); capSched.delete(); capHi.delete(); capLo.delete();
        for (int i = 0; i < nPhases; i++) begin
            len = (i < forcedLen.size()) ? forcedLen[i] : int'($urandom_range(90, 8));
            if (i == nPhases - 1 && lastLen > 0) len = lastLen;
            lvl = (i % 2 == 0);
            g = 0;
            if (i == 0 && glitch0) g = 3;
            else if (len >= 24 && $urandom_range(1, 0) == 1) g = int'($urandom_range(3, 1));
            phaseStart.push_back(pinSched.size());
            phaseLen.push_back(len);
            for (int k = 0; k < len; k++) begin
                cleanSched.push_back(lvl);
                pinSched.push_back((k >= 10 && k < 10 + g) ? !lvl : lvl);
            end
        end
        total = pinSched.size();
        runLen = total - dropTail;
        for (int c = 0; c < total + LAT + 2; c++) begin
            quiet = inWindow(c, q0f, q0t, total) || inWindow(c, q1f, q1t, total);
            readySched.push_back(quiet ? 1'b0 : ($urandom_range(3, 0) != 0));
            clrSched.push_back(quiet ? 1'b0 : ($urandom_range(15, 0) == 0));
            capSched.push_back(1'b0);
            capHi.push_back(0);
            capLo.push_back(0);
        end
        // A measurement is produced at every rise that closes a low phase which
        // itself followed a complete high phase (phase 0 is the post-reset idle high).
        for (int i = 4; i < nPhases; i += 2) begin
            m = phaseStart[i] + LAT + 1;
            capSched[m] = 1'b1;
            capHi[m] = (phaseLen[i-2] > SAT) ? SAT : phaseLen[i-2];
            capLo[m] = (phaseLen[i-1] > SAT) ? SAT : phaseLen[i-1];
        end
        mValid = 1'b0; mOverrun = 1'b0; mHi = 0; mLo = 0;
        for (int c = 0; c < runLen; c++) begin
            pin_in = pinSched[c];
            meas_ready = readySched[c];
            overrun_clr = clrSched[c];
            @(posedge clk);
            drop = 1'b0;
            if (capSched[c]) begin
                if (!mValid || readySched[c]) begin
                    mValid = 1'b1; mHi = capHi[c]; mLo = capLo[c];
                end else begin
                    drop = 1'b1;
                end
            end else if (mValid && readySched[c]) begin
                mValid = 1'b0;
            end
            if (drop) mOverrun = 1'b1;
            else if (clrSched[c]) mOverrun = 1'b0;
            @(negedge clk);
            expLevel = (c >= LAT) ? cleanSched[c-LAT] : 1'b1;
            prevLevel = (c >= LAT + 1) ? cleanSched[c-LAT-1] : 1'b1;
            checkOutput($sformatf("%s.level@%0d", seg, c), level, expLevel);
            checkOutput($sformatf("%s.rise@%0d", seg, c), rise_pulse, expLevel & !prevLevel);
            checkOutput($sformatf("%s.fall@%0d", seg, c), fall_pulse, !expLevel & prevLevel);
            checkOutput($sformatf("%s.meas_valid@%0d", seg, c), meas_valid, mValid);
            checkOutput($sformatf("%s.overrun@%0d", seg, c), overrun, mOverrun);
            if (mValid) begin
                checkOutput($sformatf("%s.high_count@%0d", seg, c), high_count, mHi);
                checkOutput($sformatf("%s.low_count@%0d", seg, c), low_count, mLo);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset.level", level, 1'b1);
        checkOutput("reset.rise", rise_pulse, 1'b0);
        checkOutput("reset.fall", fall_pulse, 1'b0);
        checkOutput("reset.meas_valid", meas_valid, 1'b0);
        checkOutput("reset.overrun", overrun, 1'b0);
        checkOutput("reset.high_count", high_count, 0);
        checkOutput("reset.low_count", low_count, 0);
        rst_n = 1'b1;

        // 3-cycle glitch in the idle high, 100/60 periods, a saturating 300-cycle
        // high, a stalled consumer across two periods, and a stall up to a mid-low stop.
        forcedLen = '{30, 40, 100, 60, 300, 60, 100, 60};
        glitch0 = 1'b1;
        applyStimulus("seg1", 22, 20, 40, 9, 13, 17, 22);

        checkOutput("preReset.level", level, 1'b0);
        checkOutput("preReset.meas_valid", meas_valid, 1'b1);
        checkOutput("preReset.overrun", overrun, 1'b1);
        #2 rst_n = 1'b0;
        pin_in = 1'b1;
        meas_ready = 1'b0;
        overrun_clr = 1'b0;
        #1;
        checkOutput("midReset.level", level, 1'b1);
        checkOutput("midReset.rise", rise_pulse, 1'b0);
        checkOutput("midReset.fall", fall_pulse, 1'b0);
        checkOutput("midReset.meas_valid", meas_valid, 1'b0);
        checkOutput("midReset.overrun", overrun, 1'b0);
        checkOutput("midReset.high_count", high_count, 0);
        checkOutput("midReset.low_count", low_count, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // After release the first full period must not yield a measurement.
        forcedLen = '{20, 50, 70, 40, 80, 45};
        glitch0 = 1'b0;
        applyStimulus("seg2", 10, 0, 0, -1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
